// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
// Optional return-address stack is enabled with PC_RAS_EN.
package pc_pkg;

  typedef enum logic [1:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JR,
    SRC_J
  } src_t;

  localparam int unsigned PC_INCR = 4;

  // Word offset from imm16, sign-extended and masked to width bits.
  function automatic logic [31:0] sext_shift(
    input logic [15:0] imm16,
    input int unsigned width
  );
    logic [31:0] v;
    v = {{14{imm16[15]}}, imm16, 2'b00};
    if (width < 32) v = v & ((32'd1 << width) - 32'd1);
    return v;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full drops the oldest entry.
// Used by pc_sequencer only when PC_RAS_EN is defined.
module pc_ras
  import pc_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data,
  output logic [W-1:0] top,
  output logic [4:0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;

  assign top = mem[wp - PW'(1)];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wp] <= data;
      wp      <= wp + PW'(1);
      if (count != 5'(DEPTH)) count <= count + 5'd1;
    end else if (pop) begin
      wp    <= wp - PW'(1);
      count <= count - 5'd1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Registered PC with branch/jr/j/jal next-PC priority mux and misalign flag.
// Define PC_RAS_EN to add a return-address stack for jal/jr.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [31:0]       instr,
  input  logic              branch,
  input  logic              bne,
  input  logic              zero,
  input  logic              jump,
  input  logic              jal,
  input  logic              jr,
  input  logic [ADDR_W-1:0] rs_val,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              redirect,
  output logic              misalign,
  output logic [4:0]        ras_count
);

  logic              taken;
  logic [31:0]       imm_ext;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] jr_tgt;
  logic [ADDR_W-1:0] nxt;
  src_t              src;
  logic              unused_ok;

  assign taken    = branch & (zero ^ bne);
  assign pc_plus4 = pc + ADDR_W'(PC_INCR);
  assign imm_ext  = sext_shift(instr[15:0], ADDR_W);
  assign br_tgt   = pc_plus4 + imm_ext[ADDR_W-1:0];

  generate
    if (ADDR_W == 28) begin : g_j28
      assign j_tgt = {instr[25:0], 2'b00};
    end else begin : g_jw
      assign j_tgt = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};
    end
  endgenerate

  always_comb begin
    src = SRC_SEQ;
    nxt = pc_plus4;
    priority case (1'b1)
      taken: begin
        src = SRC_BR;
        nxt = br_tgt;
      end
      jr: begin
        src = SRC_JR;
        nxt = jr_tgt;
      end
      (jump | jal): begin
        src = SRC_J;
        nxt = j_tgt;
      end
      default: ;
    endcase
  end

  assign redirect = (src != SRC_SEQ);

`ifdef PC_RAS_EN
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] top;
  logic [4:0]        cnt;

  // Only the winning source may touch the stack.
  assign push = !stall && (src == SRC_J) && jal;
  assign pop  = !stall && (src == SRC_JR) && (cnt != 5'd0);

  pc_ras #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .data  (pc_plus4),
    .top   (top),
    .count (cnt)
  );

  assign jr_tgt    = (cnt != 5'd0) ? top : rs_val;
  assign ras_count = cnt;
  assign unused_ok = ^instr[31:26];
`else
  assign jr_tgt    = rs_val;
  assign ras_count = '0;
  assign unused_ok = ^{instr[31:26], RAS_DEPTH};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_VEC;
      misalign <= 1'b0;
    end else if (!stall) begin
      pc       <= nxt;
      misalign <= |nxt[1:0];
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a queue-based model.
// Stack-specific checks are compiled in when PC_RAS_EN is defined.
module tb_pc_sequencer;

  localparam int          AW    = 32;
  localparam logic [31:0] RV    = 32'h400;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, stall, branch, bne, zero, jump, jal, jr;
  logic [31:0] instr, rs_val;
  logic [31:0] pc, pc_plus4;
  logic        redirect, misalign;
  logic [4:0]  ras_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_q [$];
  bit          known = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W    (AW),
    .RESET_VEC (RV),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .instr     (instr),
    .branch    (branch),
    .bne       (bne),
    .zero      (zero),
    .jump      (jump),
    .jal       (jal),
    .jr        (jr),
    .rs_val    (rs_val),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .redirect  (redirect),
    .misalign  (misalign),
    .ras_count (ras_count)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_cnt();
`ifdef PC_RAS_EN
    return 32'(m_q.size());
`else
    return 32'd0;
`endif
  endfunction

  task automatic step(input logic r, s, b, n, z, j, l, rj,
                      input logic [31:0] ins, rs);
    logic        tk;
    logic [31:0] p4, nx;
    rst_n = r; stall = s; branch = b; bne = n; zero = z;
    jump = j; jal = l; jr = rj; instr = ins; rs_val = rs;
    #1;
    tk = b & (z ^ n);
    check("redirect", 32'(redirect), 32'(tk | rj | j | l));
    if (known) check("pc_plus4", pc_plus4, m_pc + 32'd4);
    p4 = m_pc + 32'd4;
    if (!r) begin
      m_pc = RV; m_mis = 1'b0; m_q.delete(); known = 1;
    end else if (!s) begin
      if (tk) begin
        nx = p4 + {{14{ins[15]}}, ins[15:0], 2'b00};
      end else if (rj) begin
        nx = rs;
`ifdef PC_RAS_EN
        if (m_q.size() > 0) nx = m_q.pop_back();
`endif
      end else if (j | l) begin
        nx = {p4[31:28], ins[25:0], 2'b00};
`ifdef PC_RAS_EN
        if (l) begin
          if (m_q.size() == DEPTH) void'(m_q.pop_front());
          m_q.push_back(p4);
        end
`endif
      end else begin
        nx = p4;
      end
      m_pc = nx;
      m_mis = (nx[1:0] != 2'b00);
    end
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("misalign", 32'(misalign), 32'(m_mis));
    check("ras_count", 32'(ras_count), m_cnt());
    @(negedge clk);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic go_jr(input logic [31:0] rs);
    step(1, 0, 0, 0, 0, 0, 0, 1, 32'h0, rs);
  endtask

  initial begin
    logic [31:0] exp_pops [5];
    exp_pops = '{32'h54, 32'h44, 32'h34, 32'h24, 32'hBEEF0};
    rst_n = 0; stall = 0; branch = 0; bne = 0; zero = 0;
    jump = 0; jal = 0; jr = 0; instr = 0; rs_val = 0;
    @(negedge clk);

    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 1, 1, 0, 1, 1, 1, 1, 32'hFFFF, 32'h123);
    check("rst_pc", pc, 32'h400);
    check("rst_cnt", 32'(ras_count), 32'd0);
    idle(); check("seq1", pc, 32'h404);
    idle(); check("seq2", pc, 32'h408);
    idle(); check("seq3", pc, 32'h40C);

    go_jr(32'h1000);
    step(1, 0, 1, 0, 1, 0, 0, 0, 32'h0000FFFE, 32'h0);
    check("beq_back", pc, 32'h0FFC);
    go_jr(32'h1000);
    step(1, 0, 1, 0, 0, 0, 0, 0, 32'h0000FFFE, 32'h0);
    check("beq_fall", pc, 32'h1004);

    go_jr(32'h1000);
    step(1, 0, 1, 1, 0, 1, 0, 0, 32'h00000010, 32'h0);
    check("br_over_j", pc, 32'h1044);
    step(1, 0, 1, 1, 1, 1, 0, 0, 32'h00000010, 32'h0);
    check("j_when_nt", pc, 32'h40);

`ifdef PC_RAS_EN
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    go_jr(32'h10);
    for (int k = 1; k <= 5; k++)
      step(1, 0, 0, 0, 0, 0, 1, 0, 32'(((k + 1) * 16) >> 2), 32'h0);
    check("ras_full", 32'(ras_count), 32'd4);
    for (int k = 0; k < 5; k++) begin
      go_jr(32'hBEEF0);
      check("ras_pop", pc, exp_pops[k]);
    end
    check("ras_empty", 32'(ras_count), 32'd0);
`endif

    for (int k = 0; k < 3; k++)
      step(1, 1, 0, 0, 0, 0, 1, 0, 32'h20, 32'h0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 32'h20, 32'h0);
    check("stall_jal", pc, 32'h80);

    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    go_jr(32'h102);
    check("mis_pc", pc, 32'h102);
    check("mis_set", 32'(misalign), 32'd1);
    idle();
    check("mis_seq", pc, 32'h106);
    check("mis_hold", 32'(misalign), 32'd1);
    go_jr(32'h200);
    check("mis_clr", 32'(misalign), 32'd0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 32'h55, 32'h0);
    check("mid_rst", pc, 32'h400);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] rs;
      rs = $urandom();
      if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
      step($urandom_range(0, 39) != 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 4) == 0,
           $urandom(), rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
